// File: rtl/reflet_fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field geometry, converter states, float classes.
package reflet_fpu_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_FRAC_W   = 23;
  localparam logic [FP_EXP_W-1:0] FP_EXP_SPECIAL = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} cvt_state_e;

  typedef enum logic [2:0] {FC_ZERO, FC_DENORM, FC_NORMAL, FC_INF, FC_NAN} fp_class_e;

  typedef struct packed {
    logic                  sign;
    logic [FP_EXP_W-1:0]   exp;
    logic [FP_FRAC_W:0]    mant;     // hidden bit included for normals
    logic                  frac_nz;
    fp_class_e             cls;
  } fp_unpacked_t;

endpackage

// File: rtl/reflet_float_to_int_if.sv
// Handshake bundle between a float producer / int consumer and the float->int converter.
interface reflet_float_to_int_if #(parameter int INT_WIDTH = 16);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          float_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [INT_WIDTH-1:0] int_out;
  logic                 f_overflow;
  logic                 f_invalid;
  logic                 f_inexact;

  modport master (
    output in_valid, float_in, out_ready,
    input  in_ready, out_valid, int_out, f_overflow, f_invalid, f_inexact
  );

  modport slave (
    input  in_valid, float_in, out_ready,
    output in_ready, out_valid, int_out, f_overflow, f_invalid, f_inexact
  );
endinterface

// File: rtl/reflet_float_unpack.sv
// Combinational IEEE-754 single unpacker: fields, hidden bit and class.
module reflet_float_unpack
  import reflet_fpu_pkg::*;
(
  input  logic [31:0]  f,
  output fp_unpacked_t u
);
  always_comb begin
    u.sign    = f[31];
    u.exp     = f[30:23];
    u.frac_nz = |f[22:0];
    u.mant    = {(f[30:23] != '0), f[22:0]};
    if (f[30:23] == FP_EXP_SPECIAL) u.cls = u.frac_nz ? FC_NAN : FC_INF;
    else if (f[30:23] == '0)        u.cls = u.frac_nz ? FC_DENORM : FC_ZERO;
    else                            u.cls = FC_NORMAL;
  end
endmodule

// File: rtl/reflet_float_to_int.sv
// Multi-cycle float32 -> signed INT_WIDTH converter, truncating, saturating, serial shifter.
module reflet_float_to_int
  import reflet_fpu_pkg::*;
#(
  parameter int INT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  reflet_float_to_int_if.slave bus
);
  localparam logic [INT_WIDTH-1:0] SAT_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] SAT_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam int E_MAX  = FP_EXP_BIAS + INT_WIDTH - 1;
  localparam int S_BASE = FP_EXP_BIAS + FP_FRAC_W;

  cvt_state_e           state, state_nx;
  logic [31:0]          f_reg;
  fp_unpacked_t         u;
  logic [FP_FRAC_W:0]   acc;
  logic [4:0]           cnt;
  logic                 sticky, special, ovf_range;
  logic [INT_WIDTH-1:0] mag, int_q;
  logic                 ovf_q, inv_q, inx_q;

  reflet_float_unpack u_unpack (.f(f_reg), .u(u));

  assign bus.in_ready   = (state == ST_IDLE);
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.int_out    = int_q;
  assign bus.f_overflow = ovf_q;
  assign bus.f_invalid  = inv_q;
  assign bus.f_inexact  = inx_q;
  assign mag            = acc[INT_WIDTH-1:0];

  // Only -2^(INT_WIDTH-1) survives at the top exponent.
  assign ovf_range = (int'(u.exp) > E_MAX) ||
                     ((int'(u.exp) == E_MAX) && !(u.sign && !u.frac_nz));

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.in_valid)  state_nx = ST_LOAD;
      ST_LOAD:                     state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == '0)     state_nx = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_nx = ST_IDLE;
      default:                     state_nx = ST_IDLE;
    endcase
  end

  // Specials settle their result in LOAD and pass through one SHIFT cycle with cnt=0,
  // giving them a fixed two-edge latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_reg <= '0; acc <= '0; cnt <= '0; sticky <= 1'b0; special <= 1'b0;
      int_q <= '0; ovf_q <= 1'b0; inv_q <= 1'b0; inx_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) f_reg <= bus.float_in;
        ST_LOAD: begin
          acc     <= u.mant;
          sticky  <= 1'b0;
          cnt     <= '0;
          special <= 1'b1;
          case (u.cls)
            FC_NAN: begin
              int_q <= '0; {ovf_q, inv_q, inx_q} <= 3'b010;
            end
            FC_INF: begin
              int_q <= u.sign ? SAT_NEG : SAT_POS; {ovf_q, inv_q, inx_q} <= 3'b100;
            end
            FC_ZERO: begin
              int_q <= '0; {ovf_q, inv_q, inx_q} <= 3'b000;
            end
            FC_DENORM: begin
              int_q <= '0; {ovf_q, inv_q, inx_q} <= 3'b001;
            end
            default: begin
              if (int'(u.exp) < FP_EXP_BIAS) begin
                int_q <= '0; {ovf_q, inv_q, inx_q} <= 3'b001;
              end else if (ovf_range) begin
                int_q <= u.sign ? SAT_NEG : SAT_POS; {ovf_q, inv_q, inx_q} <= 3'b100;
              end else begin
                special <= 1'b0;
                cnt     <= 5'(S_BASE - int'(u.exp));
              end
            end
          endcase
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            acc    <= acc >> 1;
            sticky <= sticky | acc[0];
            cnt    <= cnt - 5'd1;
          end else if (!special) begin
            int_q <= u.sign ? (~mag + 1'b1) : mag;
            {ovf_q, inv_q, inx_q} <= {2'b00, sticky};
          end
        end
        default: ;
      endcase
    end
  end
endmodule
